// File: rtl/branch_predictor_pkg.sv
// Shared core definitions for the fetch-side branch predictor.
//   ctr_state_e : 2-bit saturating direction counter states.
//   branch_op_e : branch classes seen by the core (kept alongside the counter
//                 type so decode/execute and the predictor share one source).
//   pc_plus4()  : sequential next-PC, wrapping modulo 2^32.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_state_e;

  typedef enum logic [1:0] {
    BR_OP_NONE = 2'b00,
    BR_OP_COND = 2'b01,
    BR_OP_JAL  = 2'b10,
    BR_OP_JALR = 2'b11
  } branch_op_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Plain 32-bit add: 0xFFFF_FFFC + 4 naturally wraps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// bp_sat_counter: next-state logic of a 2-bit saturating direction counter.
//   state      : current counter state
//   taken      : resolved branch direction
//   state_next : counter after one step (taken counts up, not-taken down,
//                holding at ST and SNT)
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  ctr_state_e state,
  input  logic       taken,
  output ctr_state_e state_next
);

  always_comb begin
    state_next = state;
    case (state)
      CTR_SNT: state_next = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: state_next = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  state_next = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  state_next = taken ? CTR_ST  : CTR_WT;
      default: state_next = state;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   flush_i                : invalidate every entry (fence.i)
//   lookup_valid_i/pc_i    : fetch prediction request
//   pred_valid/taken/target: registered prediction, one cycle after request
//   upd_*                  : resolved conditional branch from execute
//   mispredict_o           : registered one-cycle redirect pulse
//   redirect_pc_o          : correct next PC while mispredict_o is high
// Valid semantics: there is no back-pressure. lookup_valid_i and upd_valid_i
// qualify their payloads in the cycle they are high; pred_valid_o qualifies
// the pred_* payload exactly one cycle later, and pred_* is zero otherwise.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        lookup_valid_i,
  input  logic [31:0] lookup_pc_i,
  output logic        pred_valid_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_pred_taken_i,
  input  logic [31:0] upd_pred_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = 30 - IDX;

  // Flop arrays so reset and flush can clear every entry in one cycle.
  logic              tbl_valid  [ENTRIES];
  logic [TW-1:0]     tbl_tag    [ENTRIES];
  logic [31:0]       tbl_target [ENTRIES];
  ctr_state_e        tbl_ctr    [ENTRIES];

  logic [IDX-1:0] lk_idx, up_idx;
  logic [TW-1:0]  lk_tag, up_tag;
  logic           lk_hit, lk_taken, up_hit;
  logic [31:0]    lk_target, up_redirect;
  logic           up_mispredict;
  ctr_state_e     up_ctr_next;

  assign lk_idx = lookup_pc_i[IDX+1:2];
  assign lk_tag = lookup_pc_i[31:IDX+2];
  assign up_idx = upd_pc_i[IDX+1:2];
  assign up_tag = upd_pc_i[31:IDX+2];

  // Reads see the table before this cycle's write (read-before-write).
  // A flush in the same cycle forces a miss.
  assign lk_hit    = !flush_i && tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);
  assign lk_taken  = lk_hit && ((tbl_ctr[lk_idx] == CTR_WT) || (tbl_ctr[lk_idx] == CTR_ST));
  assign lk_target = lk_taken ? tbl_target[lk_idx] : pc_plus4(lookup_pc_i);

  assign up_hit = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);

  bp_sat_counter u_sat_counter (
    .state      (tbl_ctr[up_idx]),
    .taken      (upd_taken_i),
    .state_next (up_ctr_next)
  );

  // A wrong direction, or a correctly predicted taken branch whose target
  // differs, both require a redirect. Computed even while flushing.
  assign up_mispredict = upd_valid_i &&
                         ((upd_taken_i != upd_pred_taken_i) ||
                          (upd_taken_i && upd_pred_taken_i &&
                           (upd_target_i != upd_pred_target_i)));
  assign up_redirect   = upd_taken_i ? upd_target_i : pc_plus4(upd_pc_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_valid_o  <= 1'b0;
      pred_taken_o  <= 1'b0;
      pred_target_o <= '0;
      mispredict_o  <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      pred_valid_o  <= lookup_valid_i;
      pred_taken_o  <= lookup_valid_i && lk_taken;
      pred_target_o <= lookup_valid_i ? lk_target : '0;
      mispredict_o  <= up_mispredict;
      redirect_pc_o <= up_mispredict ? up_redirect : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_ctr[i]    <= CTR_WNT;
      end
    end else if (flush_i) begin
      // Any same-cycle update is intentionally dropped.
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i] <= 1'b0;
      end
    end else if (upd_valid_i) begin
      if (up_hit) begin
        tbl_ctr[up_idx] <= up_ctr_next;
        if (upd_taken_i) begin
          tbl_target[up_idx] <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        // Miss on a taken branch: claim the slot, evicting any occupant.
        tbl_valid[up_idx]  <= 1'b1;
        tbl_tag[up_idx]    <= up_tag;
        tbl_target[up_idx] <= upd_target_i;
        tbl_ctr[up_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES = 64): directed cases for
// the documented scenarios followed by randomized traffic, all compared
// against a table-level behavioural model.
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int IDX     = 6;
  localparam int W       = 67;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, lookup_valid_i, upd_valid_i;
  logic        upd_taken_i, upd_pred_taken_i;
  logic [31:0] lookup_pc_i, upd_pc_i, upd_target_i, upd_pred_target_i;
  logic        pred_valid_o, pred_taken_o, mispredict_o;
  logic [31:0] pred_target_o, redirect_pc_o;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .flush_i           (flush_i),
    .lookup_valid_i    (lookup_valid_i),
    .lookup_pc_i       (lookup_pc_i),
    .pred_valid_o      (pred_valid_o),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
    .mispredict_o      (mispredict_o),
    .redirect_pc_o     (redirect_pc_o)
  );

  // ---------------- reference model ----------------
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];   // 0..3, >= 2 means predict taken

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int check_count = 0;
  int pass_count  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- driver ----------------
  // Drives one cycle, predicts its registered outputs from the model, steps
  // the model, then samples the DUT 1 time unit after the edge.
  task automatic step(input logic r, input logic f,
                      input logic lv, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic upt,
                      input logic [31:0] uptgt);
    int          li, ui;
    bit          lhit, uhit, pt, mp;
    logic [31:0] ptgt, rd;
    logic [W-1:0] e;

    rst_i = r; flush_i = f;
    lookup_valid_i = lv; lookup_pc_i = lpc;
    upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut;
    upd_target_i = utgt; upd_pred_taken_i = upt; upd_pred_target_i = uptgt;

    li = int'((lpc >> 2) % ENTRIES);
    ui = int'((upc >> 2) % ENTRIES);
    lhit = !f && m_valid[li] && (m_tag[li] == (lpc >> (IDX + 2)));
    uhit = m_valid[ui] && (m_tag[ui] == (upc >> (IDX + 2)));
    pt   = lv && lhit && (m_ctr[li] >= 2);
    ptgt = !lv ? 32'h0 : (pt ? m_tgt[li] : lpc + 32'd4);
    mp   = uv && ((ut != upt) || (ut && utgt != uptgt));
    rd   = !mp ? 32'h0 : (ut ? utgt : upc + 32'd4);

    if (r) begin
      e = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0; m_ctr[i] = 1;
      end
    end else begin
      e = {lv, pt, ptgt, mp, rd};
      if (f) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      end else if (uv) begin
        if (uhit) begin
          m_ctr[ui] = ut ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3)
                         : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
          if (ut) m_tgt[ui] = utgt;
        end else if (ut) begin
          m_valid[ui] = 1; m_tag[ui] = upc >> (IDX + 2);
          m_tgt[ui] = utgt; m_ctr[ui] = 2;
        end
      end
    end
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pred_valid",  {31'b0, pred_valid_o},  {31'b0, e[66]});
    check("pred_taken",  {31'b0, pred_taken_o},  {31'b0, e[65]});
    check("pred_target", pred_target_o,          e[64:33]);
    check("mispredict",  {31'b0, mispredict_o},  {31'b0, e[32]});
    check("redirect_pc", redirect_pc_o,          e[31:0]);
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(0, 0, 1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptgt);
    step(0, 0, 0, 0, 1, pc, t, tgt, pt, ptgt);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC - ($urandom_range(0, 3) << 2);
    else pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
    return pc;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, b, t;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_pred_valid", {31'b0, pred_valid_o}, 32'h0);
    check("reset_mispredict", {31'b0, mispredict_o}, 32'h0);

    // Cold lookup falls through to pc+4.
    lookup(32'h0000_0100);
    check("cold_taken",  {31'b0, pred_taken_o}, 32'h0);
    check("cold_target", pred_target_o, 32'h0000_0104);

    // Allocation on a mispredicted taken branch.
    update(32'h100, 1, 32'h200, 0, 32'h0);
    check("alloc_mispredict", {31'b0, mispredict_o}, 32'h1);
    check("alloc_redirect", redirect_pc_o, 32'h0000_0200);
    lookup(32'h100);
    check("alloc_hit_taken",  {31'b0, pred_taken_o}, 32'h1);
    check("alloc_hit_target", pred_target_o, 32'h0000_0200);

    // WT -> WNT -> SNT, then a correctly predicted not-taken.
    update(32'h100, 0, 32'h0, 1, 32'h200);
    check("nt1_redirect", redirect_pc_o, 32'h0000_0104);
    update(32'h100, 0, 32'h0, 1, 32'h200);
    update(32'h100, 0, 32'h0, 0, 32'h0);
    check("nt3_no_mispredict", {31'b0, mispredict_o}, 32'h0);
    lookup(32'h100);
    check("snt_taken", {31'b0, pred_taken_o}, 32'h0);

    // Same index, different tag evicts.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    update(32'h100, 1, 32'h200, 0, 32'h0);
    update(32'h1100, 1, 32'h500, 0, 32'h0);
    lookup(32'h100);
    check("evict_miss_target", pred_target_o, 32'h0000_0104);
    lookup(32'h1100);
    check("evict_new_target", pred_target_o, 32'h0000_0500);

    // Read-before-write on a same-cycle lookup/update.
    update(32'h100, 1, 32'h200, 0, 32'h0);
    update(32'h100, 1, 32'h200, 1, 32'h200);
    step(0, 0, 1, 32'h100, 1, 32'h100, 1, 32'h300, 1, 32'h200);
    check("rbw_old_target", pred_target_o, 32'h0000_0200);
    check("rbw_mispredict", {31'b0, mispredict_o}, 32'h1);
    lookup(32'h100);
    check("rbw_new_target", pred_target_o, 32'h0000_0300);

    // Flush with same-cycle lookup and update.
    step(0, 1, 1, 32'h100, 1, 32'h1100, 1, 32'h700, 0, 32'h0);
    check("flush_lookup_miss", pred_target_o, 32'h0000_0104);
    check("flush_mispredict", {31'b0, mispredict_o}, 32'h1);
    lookup(32'h100);
    check("post_flush_miss", {31'b0, pred_taken_o}, 32'h0);
    lookup(32'h1100);
    check("flush_dropped_update", pred_target_o, 32'h0000_1104);
    lookup(32'hFFFF_FFFC);
    check("wrap_target", pred_target_o, 32'h0000_0000);

    // Reset overrides a pending lookup and mispredict.
    update(32'h40, 1, 32'h80, 0, 32'h0);
    step(1, 0, 1, 32'h40, 1, 32'h40, 1, 32'h90, 0, 32'h0);
    check("rst_mispredict", {31'b0, mispredict_o}, 32'h0);
    check("rst_pred_valid", {31'b0, pred_valid_o}, 32'h0);
    lookup(32'h40);
    check("rst_cleared_entry", pred_target_o, 32'h0000_0044);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      a = rand_pc();
      b = rand_pc();
      t = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 63) << 2);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
           1'($urandom_range(0, 1)), a,
           1'($urandom_range(0, 2) != 0), b, 1'($urandom_range(0, 1)), t,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) != 0) ? t : 32'($urandom));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
